// File: rtl/snake_board_render.sv
// rtl/snake_board_render.sv - 40x30 snake board cell RAM with 1-cycle VGA pixel lookup, clear sweep and frame tick
// Optional grid overlay: define GRID_LINES_EN.
module snake_board_render #(
    parameter int          GRID_W  = 40,
    parameter int          GRID_H  = 30,
    parameter logic [23:0] C_EMPTY = 24'h000000,
    parameter logic [23:0] C_BODY  = 24'h00C000,
    parameter logic [23:0] C_HEAD  = 24'h00FF00,
    parameter logic [23:0] C_FOOD  = 24'hFF0000,
    parameter logic [23:0] C_GRID  = 24'h202020
) (
    input  logic        clk_vga,
    input  logic        rst,
    input  logic [9:0]  vga_xpos,
    input  logic [9:0]  vga_ypos,
    output logic [23:0] vga_data,
    input  logic        wr_en,
    input  logic [5:0]  wr_x,
    input  logic [4:0]  wr_y,
    input  logic [1:0]  wr_code,
    input  logic        clr_req,
    output logic        busy,
    output logic        frame_tick
);

    localparam int CELLS = GRID_W * GRID_H;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t      state_q;
    logic [10:0] clr_addr_q;
    logic        busy_q;
    logic        blank_q;
    logic [9:0]  ypos_q;
    logic [1:0]  rd_code_q;
    logic [1:0]  mem [0:CELLS-1];

    // row*40 + col built from shifts
    function automatic logic [10:0] cell_addr(input logic [4:0] row, input logic [5:0] col);
        return {1'b0, row, 5'b0} + {3'b0, row, 3'b0} + {5'b0, col};
    endfunction

    logic [9:0]  px_d, py_d;
    logic        blank_d;
    logic [10:0] rd_addr_d;
    logic        wr_ok_d;
    logic        ram_we_d;
    logic [10:0] ram_waddr_d;
    logic [1:0]  ram_wdata_d;

    always_comb begin
        px_d        = (vga_xpos != 10'd0) ? vga_xpos - 10'd1 : 10'd0;
        py_d        = (vga_ypos != 10'd0) ? vga_ypos - 10'd1 : 10'd0;
        blank_d     = (vga_xpos == 10'd0) || (vga_ypos == 10'd0);
        rd_addr_d   = cell_addr(py_d[8:4], px_d[9:4]);
        wr_ok_d     = wr_en && !clr_req && (int'(wr_x) < GRID_W) && (int'(wr_y) < GRID_H);
        ram_we_d    = 1'b0;
        ram_waddr_d = cell_addr(wr_y, wr_x);
        ram_wdata_d = wr_code;
        if (!rst) begin
            if (state_q == S_CLEAR) begin
                ram_we_d    = 1'b1;
                ram_waddr_d = clr_addr_q;
                ram_wdata_d = 2'd0;
            end else begin
                ram_we_d = wr_ok_d;
            end
        end
    end

    // Read-first: the read samples the array before this edge's write lands.
    always_ff @(posedge clk_vga) begin
        if (ram_we_d)
            mem[ram_waddr_d] <= ram_wdata_d;
        rd_code_q <= mem[rd_addr_d];
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            state_q    <= S_IDLE;
            clr_addr_q <= 11'd0;
            busy_q     <= 1'b0;
            blank_q    <= 1'b1;
            ypos_q     <= 10'd0;
        end else begin
            blank_q <= blank_d;
            ypos_q  <= vga_ypos;
            case (state_q)
                S_IDLE: begin
                    if (clr_req) begin
                        state_q    <= S_CLEAR;
                        clr_addr_q <= 11'd0;
                        busy_q     <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (clr_addr_q == 11'(CELLS - 1)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        clr_addr_q <= clr_addr_q + 11'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef GRID_LINES_EN
    logic grid_q;
    always_ff @(posedge clk_vga) begin
        if (rst)
            grid_q <= 1'b0;
        else
            grid_q <= (px_d[3:0] == 4'd0) || (py_d[3:0] == 4'd0);
    end
`endif

    always_comb begin
        vga_data = C_EMPTY;
        if (blank_q) begin
            vga_data = 24'h000000;
        end else begin
            case (rd_code_q)
                2'd1:    vga_data = C_BODY;
                2'd2:    vga_data = C_HEAD;
                2'd3:    vga_data = C_FOOD;
                default: begin
`ifdef GRID_LINES_EN
                    vga_data = grid_q ? C_GRID : C_EMPTY;
`else
                    vga_data = C_EMPTY;
`endif
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign frame_tick = (ypos_q != 10'd0) && (vga_ypos == 10'd0);

endmodule

// File: tb/tb_snake_board_render.sv
// tb/tb_snake_board_render.sv - directed table-driven bench for snake_board_render
module tb_snake_board_render;

    logic        clk_vga = 1'b0;
    logic        rst;
    logic [9:0]  vga_xpos, vga_ypos;
    logic [23:0] vga_data;
    logic        wr_en;
    logic [5:0]  wr_x;
    logic [4:0]  wr_y;
    logic [1:0]  wr_code;
    logic        clr_req;
    logic        busy;
    logic        frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_vga = ~clk_vga;

    snake_board_render dut (
        .clk_vga   (clk_vga),
        .rst       (rst),
        .vga_xpos  (vga_xpos),
        .vga_ypos  (vga_ypos),
        .vga_data  (vga_data),
        .wr_en     (wr_en),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_code   (wr_code),
        .clr_req   (clr_req),
        .busy      (busy),
        .frame_tick(frame_tick)
    );

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] code;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [23:0] colour(input logic [9:0] x, input logic [9:0] y, input logic [1:0] code);
        logic [9:0] px, py;
        if (x == 10'd0 || y == 10'd0) return 24'h000000;
        px = x - 10'd1;
        py = y - 10'd1;
        case (code)
            2'd1: return 24'h00C000;
            2'd2: return 24'h00FF00;
            2'd3: return 24'hFF0000;
            default: begin
`ifdef GRID_LINES_EN
                if (px[3:0] == 4'd0 || py[3:0] == 4'd0) return 24'h202020;
`endif
                return 24'h000000;
            end
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_vga);
        #1;
    endtask

    task automatic pix(input string nm, input logic [9:0] x, input logic [9:0] y, input logic [1:0] code);
        vga_xpos = x;
        vga_ypos = y;
        step();
        chk(nm, {8'h0, vga_data}, {8'h0, colour(x, y, code)});
    endtask

    task automatic wr(input logic [5:0] x, input logic [4:0] y, input logic [1:0] c);
        wr_en = 1'b1; wr_x = x; wr_y = y; wr_code = c;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        int cnt, bad, ticks;
        logic [9:0] prev_y;

        rst = 1'b1; vga_xpos = 10'd0; vga_ypos = 10'd0;
        wr_en = 1'b0; wr_x = 6'd0; wr_y = 5'd0; wr_code = 2'd0; clr_req = 1'b0;
        step(); step();
        chk("reset_vga_data", {8'h0, vga_data}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_frame_tick", {31'h0, frame_tick}, 32'h0);
        rst = 1'b0;
        step();

        // Clear sweep; a write mid-sweep past its address must be ignored.
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        cnt = 0;
        while (busy && cnt < 2000) begin
            cnt++;
            if (cnt == 600) begin
                wr_en = 1'b1; wr_x = 6'd7; wr_y = 5'd7; wr_code = 2'd3;
            end else begin
                wr_en = 1'b0;
            end
            step();
        end
        wr_en = 1'b0;
        chk("busy_cycles", cnt, 32'd1200);

        bad = 0;
        for (int y = 1; y <= 480; y += 7) begin
            for (int x = 1; x <= 640; x += 3) begin
                vga_xpos = 10'(x); vga_ypos = 10'(y);
                step();
                if (vga_data !== colour(10'(x), 10'(y), 2'd0)) bad++;
            end
        end
        chk("cleared_frame_errors", bad, 32'd0);

        wr(6'd5, 5'd3, 2'd2);
        wr(6'd39, 5'd29, 2'd3);
        wr(6'd0, 5'd0, 2'd1);
        wr(6'd20, 5'd12, 2'd3);

        vecs[0] = '{10'd81,  10'd49,  2'd2};
        vecs[1] = '{10'd96,  10'd64,  2'd2};
        vecs[2] = '{10'd97,  10'd49,  2'd0};
        vecs[3] = '{10'd640, 10'd480, 2'd3};
        vecs[4] = '{10'd0,   10'd49,  2'd2};
        vecs[5] = '{10'd81,  10'd0,   2'd2};
        vecs[6] = '{10'd1,   10'd1,   2'd1};
        vecs[7] = '{10'd16,  10'd16,  2'd1};
        vecs[8] = '{10'd17,  10'd1,   2'd0};
        vecs[9] = '{10'd321, 10'd193, 2'd3};
        for (int i = 0; i < 10; i++)
            pix($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].code);

        pix("wr_ignored_in_clear", 10'd113, 10'd113, 2'd0);

        // Out-of-range writes that would alias onto real cells.
        wr(6'd40, 5'd0, 2'd3);
        wr(6'd45, 5'd0, 2'd3);
        wr(6'd0, 5'd30, 2'd3);
        pix("oor_x40", 10'd1, 10'd17, 2'd0);
        pix("oor_x45", 10'd81, 10'd17, 2'd0);
        pix("oor_keep_00", 10'd1, 10'd1, 2'd1);

        // Same-cycle read and write of (2,2): old colour then new.
        vga_xpos = 10'd33; vga_ypos = 10'd33;
        wr_en = 1'b1; wr_x = 6'd2; wr_y = 5'd2; wr_code = 2'd1;
        step();
        wr_en = 1'b0;
        chk("rw_same_old", {8'h0, vga_data}, {8'h0, colour(10'd33, 10'd33, 2'd0)});
        step();
        chk("rw_same_new", {8'h0, vga_data}, {8'h0, colour(10'd33, 10'd33, 2'd1)});

        // Frame tick over two compressed frames.
        vga_xpos = 10'd0;
        ticks = 0; bad = 0; prev_y = 10'd0;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 525; i++) begin
                vga_ypos = (i < 480) ? 10'(i + 1) : 10'd0;
                @(negedge clk_vga);
                if (frame_tick) begin
                    ticks++;
                    if (prev_y != 10'd480) bad++;
                end
                prev_y = vga_ypos;
                step();
            end
        end
        chk("frame_tick_count", ticks, 32'd2);
        chk("frame_tick_misplaced", bad, 32'd0);

        // Clear with simultaneous write, reset after 500 cleared cells.
        wr(6'd19, 5'd12, 2'd1);
        clr_req = 1'b1;
        wr_en = 1'b1; wr_x = 6'd30; wr_y = 5'd20; wr_code = 2'd2;
        step();
        clr_req = 1'b0; wr_en = 1'b0;
        chk("busy_after_clr", {31'h0, busy}, 32'h1);
        repeat (500) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("busy_after_rst", {31'h0, busy}, 32'h0);
        chk("vga_after_rst", {8'h0, vga_data}, 32'h0);
        pix("abort_addr499_cleared", 10'd305, 10'd193, 2'd0);
        pix("abort_addr500_kept", 10'd321, 10'd193, 2'd3);
        pix("abort_addr1199_kept", 10'd640, 10'd480, 2'd3);
        pix("abort_addr125_cleared", 10'd81, 10'd49, 2'd0);
        pix("clr_wins_write_dropped", 10'd481, 10'd321, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
